vscale_fetch_stage: RTL
=======================

Name: vscale_fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC mux.
- Takes the mux's next-PC (PC_PIF) and issues it to instruction memory over a valid/ready request channel.
- Tracks up to two outstanding requests and buffers returned instructions, with their PCs, in a 2-entry queue that feeds decode (DX) through a valid/ready handshake.
- Returns the most recently issued address to the PC mux as PC_IF.
- On control-flow redirects, discards stale responses.

Parameters:
- XPR_LEN, 32, address/data width.
- INST_WIDTH, 32, instruction width.
- START_ADDR, 32'h200, first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- PC_PIF  in  XPR_LEN  next fetch address from the PC mux.
- redirect  in  1  PC_PIF is a non-sequential target (JAL/JALR/branch/handler/EPC); flush the stage.
- PC_IF  out  XPR_LEN  address of the last accepted imem request; fed back to the PC mux.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  XPR_LEN  request address.
- imem_resp_valid  in  1  response valid; in order, 1 per accepted request, never back-pressured.
- imem_resp_data  in  INST_WIDTH  response instruction.
- inst_valid_FD  out  1  queue head valid to decode.
- inst_ready_FD  in  1  decode consumes the head.
- inst_FD  out  INST_WIDTH  head instruction.
- PC_FD  out  XPR_LEN  head PC.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=BOOT, PC_IF=START_ADDR-4, queue empty, outstanding=0.
  - imem_req_valid=0, inst_valid_FD=0, inst_FD=0, PC_FD=0.
  - Reset mid-operation discards all queue contents and in-flight tracking; responses to pre-reset requests arriving after reset are ignored while in BOOT.
- FSM states BOOT, RUN, FLUSH:
  - BOOT: lasts 1 cycle, then RUN, with next request address = START_ADDR.
  - RUN: imem_req_valid = (outstanding + queue_count < 2). imem_addr = PC_PIF, except on the first RUN cycle after BOOT, when it is START_ADDR.
  - Accepted request (valid & ready): PC_IF <= imem_addr at the next edge; the address is pushed to a 2-deep in-flight PC FIFO; outstanding++.
  - Response: pop the in-flight PC; push {PC, data} to the queue; outstanding--. A request and a response in the same cycle leave outstanding unchanged.
  - Queue pop: on inst_valid_FD & inst_ready_FD. Push and pop in the same cycle are allowed, including when the queue is full.
  - Credit rule: the queue can never overflow. Overflow is an assertion error.
- Redirect (in RUN):
  - Queue is cleared the same cycle; inst_valid_FD=0 from the next cycle.
  - PC_PIF is latched into redirect_pc.
  - Any request accepted in the redirect cycle is treated as stale.
  - If outstanding (after that cycle's updates) = 0: stay in RUN and issue redirect_pc next cycle.
  - Otherwise go to FLUSH.
- FLUSH:
  - imem_req_valid=0.
  - Responses decrement outstanding and are dropped.
  - When outstanding reaches 0, go to RUN; the first request is redirect_pc, which then sets PC_IF.
  - A further redirect in FLUSH overwrites redirect_pc.
- Stall: inst_ready_FD=0 holds the head stable (inst_FD/PC_FD unchanged). Requests stop once outstanding + queue_count = 2.
- Widths: all address arithmetic is XPR_LEN, wrapping mod 2^XPR_LEN. outstanding is 2 bits, range 0..2.
- Simultaneous events: a redirect in the same cycle as a decode pop, or as a response, clears the queue; the response is dropped.
- Latency: request accepted at cycle N, response at N+k (k≥1), inst_valid_FD at N+k+1 if the queue was empty.

Test Plan:
- Reset release, imem always ready, 1-cycle response → requests 0x200, 0x204, 0x208…; PC_FD/inst_FD match in order; first inst_valid_FD 3 cycles after reset release.
- inst_ready_FD=0 for 10 cycles → exactly 2 requests in flight/buffered; head stays PC 0x200; on release, pops 0x200, 0x204 with no loss or duplication.
- imem_req_ready low for 5 cycles → imem_addr/imem_req_valid stable; PC_IF unchanged until acceptance.
- Redirect to 0x1000 with 2 outstanding (responses delayed 4 cycles) → FLUSH, both responses dropped, next request 0x1000, first inst to decode has PC_FD=0x1000.
- Redirect coincident with a response and a decode pop → queue empty next cycle, no stale PC ever presented.
- reset_n asserted mid-FLUSH → next-cycle outputs at reset values; restart from 0x200.

Source files
------------

// File: rtl/vscale_fetch_stage.sv
// Instruction-fetch stage: issues PC_PIF to instruction memory, tracks up to
// two in-flight requests, and buffers returned instructions with their PCs in
// a 2-entry queue that feeds decode. Redirects flush the queue and drop any
// responses still in flight.
module vscale_fetch_stage #(
    parameter int                 XPR_LEN    = 32,
    parameter int                 INST_WIDTH = 32,
    parameter logic [XPR_LEN-1:0] START_ADDR = XPR_LEN'(32'h200)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [XPR_LEN-1:0]    PC_PIF,
    input  logic                  redirect,
    output logic [XPR_LEN-1:0]    PC_IF,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [XPR_LEN-1:0]    imem_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    output logic                  inst_valid_FD,
    input  logic                  inst_ready_FD,
    output logic [INST_WIDTH-1:0] inst_FD,
    output logic [XPR_LEN-1:0]    PC_FD
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t               state;
    logic                 first_run;    // next request is START_ADDR
    logic                 use_redir;    // next request is redirect_pc
    logic [XPR_LEN-1:0]   redirect_pc;

    // In-flight PC FIFO: its occupancy is exactly 'outstanding'
    logic [XPR_LEN-1:0]   if_pc [2];
    logic                 if_wr;
    logic                 if_rd;
    logic [1:0]           outstanding;

    // Decode-facing instruction queue
    logic [XPR_LEN-1:0]   q_pc   [2];
    logic [INST_WIDTH-1:0] q_inst [2];
    logic                 q_wr;
    logic                 q_rd;
    logic [1:0]           q_count;

    logic                 req_fire;
    logic                 resp_fire;
    logic                 q_push;
    logic                 q_pop;
    logic                 redirect_run;
    logic [1:0]           out_next;

    // Request channel, handshake decode and next outstanding count
    always_comb begin
        imem_req_valid = (state == RUN) &&
                         (({1'b0, outstanding} + {1'b0, q_count}) < 3'd2);
        imem_addr      = first_run ? START_ADDR :
                         (use_redir ? redirect_pc : PC_PIF);
        req_fire       = imem_req_valid && imem_req_ready;
        // Responses with nothing tracked (e.g. to pre-reset requests) are ignored
        resp_fire      = imem_resp_valid && (state != BOOT) && (outstanding != 2'd0);
        redirect_run   = redirect && (state == RUN);
        q_pop          = inst_valid_FD && inst_ready_FD;
        q_push         = resp_fire && (state == RUN) && !redirect;
        out_next       = outstanding;
        case ({req_fire, resp_fire})
            2'b10:   out_next = outstanding + 2'd1;
            2'b01:   out_next = outstanding - 2'd1;
            default: out_next = outstanding;
        endcase
    end

    // Decode-facing outputs; data reads as zero while the queue is empty
    always_comb begin
        inst_valid_FD = (q_count != 2'd0);
        inst_FD       = inst_valid_FD ? q_inst[q_rd] : '0;
        PC_FD         = inst_valid_FD ? q_pc[q_rd]   : '0;
    end

    // Control FSM, PC_IF feedback and in-flight tracking
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= BOOT;
            first_run   <= 1'b0;
            use_redir   <= 1'b0;
            PC_IF       <= START_ADDR - XPR_LEN'(4);
            if_wr       <= 1'b0;
            if_rd       <= 1'b0;
            outstanding <= 2'd0;
        end else begin
            case (state)
                BOOT: begin
                    state     <= RUN;
                    first_run <= 1'b1;
                end
                RUN: begin
                    if (req_fire) begin
                        first_run <= 1'b0;
                        use_redir <= 1'b0;
                    end
                    // A request accepted this cycle is stale; its response is dropped
                    if (redirect) begin
                        redirect_pc <= PC_PIF;
                        first_run   <= 1'b0;
                        use_redir   <= 1'b1;
                        if (out_next != 2'd0)
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (redirect)
                        redirect_pc <= PC_PIF;
                    if (out_next == 2'd0)
                        state <= RUN;
                end
                default: state <= BOOT;
            endcase

            if (req_fire) begin
                PC_IF        <= imem_addr;
                if_pc[if_wr] <= imem_addr;
                if_wr        <= ~if_wr;
            end
            if (resp_fire)
                if_rd <= ~if_rd;
            outstanding <= out_next;
        end
    end

    // Instruction queue: cleared by a redirect, otherwise push/pop
    always_ff @(posedge clk) begin
        if (!reset_n || redirect_run) begin
            q_wr    <= 1'b0;
            q_rd    <= 1'b0;
            q_count <= 2'd0;
        end else begin
            if (q_push) begin
                q_pc[q_wr]   <= if_pc[if_rd];
                q_inst[q_wr] <= imem_resp_data;
                q_wr         <= ~q_wr;
            end
            if (q_pop)
                q_rd <= ~q_rd;
            case ({q_push, q_pop})
                2'b10:   q_count <= q_count + 2'd1;
                2'b01:   q_count <= q_count - 2'd1;
                default: q_count <= q_count;
            endcase
        end
    end

    // The request credit rule must keep the queue from ever overflowing
    assert property (@(posedge clk) disable iff (!reset_n)
        !(q_push && !q_pop && (q_count == 2'd2)));
    assert property (@(posedge clk) disable iff (!reset_n)
        !(req_fire && !resp_fire && (outstanding == 2'd2)));

endmodule
